seq_add_sub_64: RTL

//  Multi-cycle 64-bit adder/subtractor that processes operands in CHUNK-bit slices, LSB slice first, with a registered carry.

---
 rtl/seq_add_sub_pkg.sv | 13 +
 rtl/chunk_adder.sv | 23 ++
 rtl/seq_add_sub_64.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/seq_add_sub_pkg.sv
// Shared types and constants for the sliced 64-bit adder/subtractor.
package seq_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder assembled from full adders.
module chunk_adder #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];

endmodule

// File: rtl/seq_add_sub_64.sv
// Multi-cycle add/sub: consumes CHUNK bits per cycle LSB-first, carry held in a flop
// between slices; valid/ready on both sides, one operation in flight at a time.
module seq_add_sub_64
  import seq_add_sub_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             carry_q, carry_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] slice_s;
  logic             slice_c;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] acc_shift;
  logic             last_slice;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  assign b_eff      = (sub == OP_SUB) ? ~in2 : in2;
  assign acc_shift  = (acc_q >> CHUNK) | (WIDTH'(slice_s) << (WIDTH - CHUNK));
  assign last_slice = (cnt_q == CW'(NCH - 1));

  // The working accumulator fills during RUN; the visible sum only updates on the last slice.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    carry_d    = carry_q;
    sign_a_d   = sign_a_q;
    sign_b_d   = sign_b_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    c_out_d    = c_out_q;
    overflow_d = overflow_q;
    zero_d     = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = in1;
          b_d      = b_eff;
          carry_d  = (sub == OP_SUB) ? 1'b1 : c_in;
          sign_a_d = in1[WIDTH-1];
          sign_b_d = b_eff[WIDTH-1];
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = acc_shift;
        carry_d = slice_c;
        cnt_d   = cnt_q + CW'(1);
        if (last_slice) begin
          cnt_d      = '0;
          sum_d      = acc_shift;
          c_out_d    = slice_c;
          overflow_d = (sign_a_q == sign_b_q) && (slice_s[CHUNK-1] != sign_a_q);
          zero_d     = (acc_shift == '0);
          state_d    = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      carry_q    <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      cnt_q      <= '0;
      sum_q      <= '0;
      c_out_q    <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      acc_q      <= acc_d;
      carry_q    <= carry_d;
      sign_a_q   <= sign_a_d;
      sign_b_q   <= sign_b_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      c_out_q    <= c_out_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule
